video_vga_scandbl: RTL
======================

// Module: video_vga_scandbl
// PURPOSE
//  VGA scan-doubler line buffer, directly downstream of the VGA horizontal sync generator.
//  - Captures one TV-rate line of pixels into a ping-pong line buffer.
//  - Replays the captured line twice at VGA rate, one replay per scanout_start pulse.
//  - Output feeds the VGA DAC mux.
// PARAMETERS
//  PIX_W     6    pixel width, {R1,R0,G1,G0,B1,B0}
//  ADDR_W    9    line buffer address width, 2**ADDR_W >= LINE_PIX
//  LINE_PIX  360  pixels stored and replayed per line
// PORTS
//  clk            in   1      master video clock (28 MHz)
//  rst            in   1      synchronous, active-high reset
//  hsync_start    in   1      TV line start pulse, 1 clk; same pulse the sync generator gets
//  tv_pix_stb     in   1      TV pixel strobe: capture tv_pix this clk when tv_pix_vld=1
//  tv_pix_vld     in   1      TV pixel is in the active window
//  tv_pix         in   PIX_W  TV-rate pixel
//  scanout_start  in   1      1-clk pulse from VGA sync: begin a replay
//  vga_pix_stb    in   1      VGA pixel strobe (2x TV rate)
//  vga_pix        out  PIX_W  doubled pixel, 0 outside an active replay
//  vga_act        out  1      1 while vga_pix carries replayed data
// BEHAVIOUR
//  Reset:
//   - vga_pix=0, vga_act=0, wbank=0, waddr=0, raddr=0, rd_busy=0, line_par=0.
//   - Buffer RAM contents are not cleared.
//  Write side:
//   - On tv_pix_stb & tv_pix_vld & waddr<LINE_PIX: mem[wbank][waddr] <= tv_pix, waddr++.
//   - Writes with waddr>=LINE_PIX are dropped; waddr saturates and never wraps.
//  Line swap:
//   - On hsync_start: wbank toggles, waddr<=0, line_par<=0.
//   - Read bank is always ~wbank, i.e. the line just completed.
//   - A write strobe in the hsync_start clk is dropped.
//  Read FSM, states IDLE and READ:
//   - IDLE -> READ on scanout_start: raddr<=0.
//   - scanout_start also updates line_par: the 1st pulse after hsync_start leaves it 0, the 2nd sets it 1.
//   - Further pulses keep line_par at 1 (saturating).
//   - READ: each vga_pix_stb issues a read of mem[~wbank][raddr], then raddr++.
//   - After the read issued at raddr==LINE_PIX-1 -> IDLE.
//   - scanout_start while in READ restarts at raddr=0; the partial line is abandoned.
//  Simultaneous hsync_start and scanout_start: the swap wins, so the replay reads the new ~wbank with line_par=0.
//  Output timing:
//   - The RAM has a synchronous read.
//   - vga_pix and vga_act are registered and update exactly 2 clk after the strobe that issued the read.
//   - They hold between strobes.
//   - 2 clk after the last read, vga_act=0 and vga_pix=0.
//  Arithmetic:
//   - raddr and waddr are ADDR_W-bit unsigned.
//   - Compares are against LINE_PIX-1 at full width; no modulo.
//  A read and a write never share a bank, so there is no port conflict.
//  rst asserted mid-replay: state is forced to IDLE and outputs go to 0 in the next clk.
// CONFIGURATION
//  VGA_SCANLINES_EN:
//   - Defined: when line_par=1, each 2-bit colour component c is output as {1'b0,c[1]}, i.e. halved.
//   - Defined: when line_par=0, pixels pass unmodified.
//   - Not defined: both replays are identical, and line_par is still kept for debug.
// STRUCTURE
//  Package video_vga_pkg:
//   - localparams PIX_W, ADDR_W, LINE_PIX.
//   - Read FSM state encoding RD_IDLE=1'b0, RD_READ=1'b1.
//   - Colour component field offsets.
//  Sub-module video_vga_linebuf: simple dual-port RAM.
//   - 2*2**ADDR_W words of PIX_W bits.
//   - Write port {wbank,waddr}; registered read port {~wbank,raddr}.
//   - Must infer block RAM.
//  Top level holds counters, FSM, line_par, dimming and output registers.
// TESTING
//  Capture and replay:
//   - Stim: hsync_start; 360 pixels with tv_pix=addr[5:0]; hsync_start; scanout_start; 360 vga_pix_stb.
//   - Expect: vga_pix sequence 0,1,..,63,0,.. with each value 2 clk after its strobe; vga_act high for exactly 360 strobes.
//  Double replay:
//   - Stim: second scanout_start.
//   - Expect: identical sequence; with VGA_SCANLINES_EN, pixel 6'b111111 comes out as 6'b010101.
//  Overflow:
//   - Stim: 400 valid TV pixels in one line.
//   - Expect: pixels 360..399 dropped; replay unchanged and still 360 long.
//  Restart:
//   - Stim: scanout_start at raddr=100.
//   - Expect: next read is address 0; vga_act stays high; 360 further pixels.
//  Collision:
//   - Stim: hsync_start and scanout_start in the same clk.
//   - Expect: replay of the just-completed line, undimmed (line_par=0).
//  Reset mid-replay:
//   - Stim: rst=1 for 1 clk at raddr=50.
//   - Expect: next clk vga_act=0 and vga_pix=0; vga_pix_stb is ignored until scanout_start.

Source files
------------

// File: rtl/video_vga_pkg.sv
// ---------------------------------------------------------------------------
// video_vga_pkg
// Shared definitions for the VGA scan-doubler slice.
//   PIX_W / ADDR_W / LINE_PIX : pixel width, line buffer address width and
//                               number of pixels captured/replayed per line
//   LINE_END / LAST_ADDR      : full-width address compare constants
//   R_LSB / G_LSB / B_LSB     : bit offsets of the 2-bit colour components
//                               inside a {R1,R0,G1,G0,B1,B0} pixel
//   rd_state_t                : replay FSM state encoding
// ---------------------------------------------------------------------------
package video_vga_pkg;

    localparam int PIX_W    = 6;
    localparam int ADDR_W   = 9;
    localparam int LINE_PIX = 360;

    localparam logic [ADDR_W-1:0] LINE_END  = ADDR_W'(LINE_PIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_PIX - 1);

    localparam int R_LSB = 4;
    localparam int G_LSB = 2;
    localparam int B_LSB = 0;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/video_vga_linebuf.sv
// ---------------------------------------------------------------------------
// video_vga_linebuf
// Simple dual-port ping-pong line buffer: two banks of 2**ADDR_W words,
// bank selected by the address MSB. One write port, one registered read port
// (synchronous read so it maps onto block RAM). No reset on the storage.
// Ports:
//   clk      in   master video clock
//   wr_en    in   write enable
//   wr_addr  in   {bank, address} write address
//   wr_pix   in   pixel to store
//   rd_en    in   read enable; rd_pix updates on the following edge
//   rd_addr  in   {bank, address} read address
//   rd_pix   out  registered read data
// ---------------------------------------------------------------------------
module video_vga_linebuf
    import video_vga_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [PIX_W-1:0]  wr_pix,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [PIX_W-1:0]  rd_pix
);

    logic [PIX_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_pix <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/video_vga_scandbl.sv
// ---------------------------------------------------------------------------
// video_vga_scandbl
// VGA scan-doubler: captures one TV-rate line into a ping-pong line buffer
// and replays the previously completed line twice at VGA rate, once per
// scanout_start pulse. Output feeds the VGA DAC mux.
// Ports:
//   clk            in   master video clock (28 MHz)
//   rst            in   synchronous, active-high reset
//   hsync_start    in   TV line start pulse: swaps banks, restarts capture
//   tv_pix_stb     in   TV pixel strobe
//   tv_pix_vld     in   TV pixel inside the active window
//   tv_pix         in   TV-rate pixel {R1,R0,G1,G0,B1,B0}
//   scanout_start  in   begin (or restart) a replay
//   vga_pix_stb    in   VGA pixel strobe (2x TV rate)
//   vga_pix        out  doubled pixel, 0 outside an active replay
//   vga_act        out  1 while vga_pix carries replayed data
// Configuration:
//   VGA_SCANLINES_EN  when defined, the second replay of each line is
//                     output with every colour component halved.
// Output timing: each strobe's result appears on vga_pix/vga_act two clocks
// after the strobe and holds until the next strobe's result.
// ---------------------------------------------------------------------------
module video_vga_scandbl
    import video_vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hsync_start,
    input  logic              tv_pix_stb,
    input  logic              tv_pix_vld,
    input  logic [PIX_W-1:0]  tv_pix,
    input  logic              scanout_start,
    input  logic              vga_pix_stb,
    output logic [PIX_W-1:0]  vga_pix,
    output logic              vga_act
);

`ifdef VGA_SCANLINES_EN
    localparam bit SCANLINES = 1'b1;
`else
    localparam bit SCANLINES = 1'b0;
`endif

    // Halve each 2-bit colour component: c -> {1'b0, c[1]}.
    function automatic logic [PIX_W-1:0] dim_pix(input logic [PIX_W-1:0] p,
                                                 input logic             half);
        logic [PIX_W-1:0] q;
        q = p;
        if (half) begin
            q[R_LSB+1] = 1'b0;
            q[R_LSB]   = p[R_LSB+1];
            q[G_LSB+1] = 1'b0;
            q[G_LSB]   = p[G_LSB+1];
            q[B_LSB+1] = 1'b0;
            q[B_LSB]   = p[B_LSB+1];
        end
        return q;
    endfunction

    logic              wbank;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              line_par;
    logic              par_seen;
    rd_state_t         rd_state;

    logic              wr_en;
    logic              rd_en;

    logic [PIX_W-1:0]  rd_pix_p0;
    logic              stb_p0;
    logic              vld_p0;
    logic              par_p0;

    // A write in the hsync_start clock is dropped; waddr saturates at LINE_PIX.
    assign wr_en = tv_pix_stb & tv_pix_vld & ~hsync_start & (waddr < LINE_END);

    // scanout_start takes the clock for the restart, so no read issues with it.
    assign rd_en = (rd_state == RD_READ) & vga_pix_stb & ~scanout_start;

    // Write side and line parity. par_seen marks that the first replay pulse
    // of this line has happened; the next pulse sets line_par.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank    <= 1'b0;
            waddr    <= '0;
            line_par <= 1'b0;
            par_seen <= 1'b0;
        end else if (hsync_start) begin
            wbank    <= ~wbank;
            waddr    <= '0;
            line_par <= 1'b0;
            par_seen <= scanout_start;
        end else begin
            if (wr_en) begin
                waddr <= waddr + 1'b1;
            end
            if (scanout_start) begin
                par_seen <= 1'b1;
                if (par_seen) begin
                    line_par <= 1'b1;
                end
            end
        end
    end

    // Replay FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            raddr    <= '0;
        end else if (scanout_start) begin
            rd_state <= RD_READ;
            raddr    <= '0;
        end else if (rd_en) begin
            raddr <= raddr + 1'b1;
            if (raddr == LAST_ADDR) begin
                rd_state <= RD_IDLE;
            end
        end
    end

    // Stage p0: RAM read register (inside linebuf) alongside strobe/valid/parity
    video_vga_linebuf u_linebuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wbank, waddr}),
        .wr_pix  (tv_pix),
        .rd_en   (rd_en),
        .rd_addr ({~wbank, raddr}),
        .rd_pix  (rd_pix_p0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            par_p0  <= 1'b0;
            vga_act <= 1'b0;
            vga_pix <= '0;
        end else begin
            stb_p0 <= vga_pix_stb;
            vld_p0 <= rd_en;
            par_p0 <= line_par & SCANLINES;
            // Stage p1: output registers, updated only by a strobe's result
            if (stb_p0) begin
                vga_act <= vld_p0;
                vga_pix <= vld_p0 ? dim_pix(rd_pix_p0, par_p0) : '0;
            end
        end
    end

endmodule
